cpld_disp_mux: RTL and testbench

// - Serial driver for the CPLD LED / 7-segment board, generalised to N multiplexed digits.
// - Frame = one serial word per digit, each ended by a latch pulse. Word carries LEDs, segments and a one-hot digit select.
// - Host updates contents via valid/ready; double-buffered so a frame never mixes old and new data.

---
 rtl/cpld_disp_mux.sv | 243 ++++++++++++++++++++++++
 tb/tb_cpld_disp_mux.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpld_disp_mux.sv
// cpld_disp_mux: serial frame driver for the CPLD LED / 7-segment board.
// Each digit gets one serial word {onehot(idx), seg_on, led} shifted LSB
// first, followed by a latch pulse and an idle hold. Host updates go into a
// shadow buffer and move to the active buffer only at the start of a frame.
// Optional macro CPLD_DISP_DIM_EN adds a brightness input and frame counter.
module cpld_disp_mux #(
  parameter int NUM_DIGITS  = 2,
  parameter int LED_W       = 8,
  parameter int CLK_DIV     = 1024,
  parameter int HOLD_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [LED_W-1:0]        upd_led,
  input  logic [4*NUM_DIGITS-1:0] upd_digits,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  input  logic                    blank,
`ifdef CPLD_DISP_DIM_EN
  input  logic [2:0]              brightness,
`endif
  output logic                    frame_done,
  output logic                    cpld_clk,
  output logic                    cpld_rstn,
  output logic                    cpld_ld,
  output logic                    cpld_mosi
);

  localparam int WORD_W  = LED_W + 8 + NUM_DIGITS;
  localparam int CNT_MAX = (2*CLK_DIV > HOLD_CYCLES) ? 2*CLK_DIV : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BIT_W   = $clog2(WORD_W);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2*CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_SHIFT, ST_LATCH, ST_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WORD_W-1:0]       word_q, word_d, load_word;
  logic                    sclk_q, sclk_d, ld_q, ld_d, mosi_q, mosi_d;
  logic                    fdone_q, fdone_d, cpld_rstn_q;
  logic                    pending_q, act_ok_q, xfer, accept;
  logic [LED_W-1:0]        act_led_q, shd_led_q;
  logic [4*NUM_DIGITS-1:0] act_dig_q, shd_dig_q;
  logic [NUM_DIGITS-1:0]   act_dp_q, shd_dp_q;
`ifdef CPLD_DISP_DIM_EN
  logic [2:0]              fcnt_q, bright_q, bright_now;
`endif

  // Active-high segment pattern for one hex digit; dp=1 lights bit 7.
  function automatic logic [7:0] seg_on(input logic [3:0] nib, input logic dp);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'hC0;  4'h1: pat = 8'hF9;  4'h2: pat = 8'hA4;  4'h3: pat = 8'hB0;
      4'h4: pat = 8'h99;  4'h5: pat = 8'h92;  4'h6: pat = 8'h82;  4'h7: pat = 8'hF8;
      4'h8: pat = 8'h80;  4'h9: pat = 8'h90;  4'hA: pat = 8'h88;  4'hB: pat = 8'h83;
      4'hC: pat = 8'hC6;  4'hD: pat = 8'hA1;  4'hE: pat = 8'h86;  4'hF: pat = 8'h8E;
    endcase
    if (dp) pat[7] = 1'b0;
    return ~pat;
  endfunction

  // A pending shadow moves to active only at LOAD of digit 0, so a frame never mixes buffers.
  assign xfer      = (state_q == ST_LOAD) && (idx_q == '0) && pending_q;
  assign upd_ready = ~pending_q | xfer;
  assign accept    = upd_valid & upd_ready;

  // Build the serial word for the current digit; the frame-start word sees the data being transferred.
  always_comb begin
    logic [LED_W-1:0]        src_led;
    logic [4*NUM_DIGITS-1:0] src_dig;
    logic [NUM_DIGITS-1:0]   src_dp;
    logic                    src_ok, show, dpb;
    logic [3:0]              nib;
    logic [7:0]              seg;
    src_led = act_led_q;
    src_dig = act_dig_q;
    src_dp  = act_dp_q;
    src_ok  = act_ok_q;
    if (xfer) begin
      src_led = shd_led_q;
      src_dig = shd_dig_q;
      src_dp  = shd_dp_q;
      src_ok  = 1'b1;
    end
    nib  = 4'(src_dig >> {idx_q, 2'b00});
    dpb  = 1'(src_dp >> idx_q);
    show = src_ok & ~blank;
`ifdef CPLD_DISP_DIM_EN
    bright_now = (idx_q == '0) ? brightness : bright_q;
    if (fcnt_q > bright_now) show = 1'b0;
`endif
    seg       = show ? seg_on(nib, dpb) : 8'h00;
    load_word = {NUM_DIGITS'(1) << idx_q, seg, src_led};
  end

  // Next-state and next-output logic for LOAD -> SHIFT -> LATCH -> HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    word_d  = word_q;
    sclk_d  = sclk_q;
    ld_d    = ld_q;
    mosi_d  = mosi_q;
    fdone_d = 1'b0;
    case (state_q)
      ST_LOAD: begin
        word_d  = load_word;
        mosi_d  = load_word[0];
        sclk_d  = 1'b0;
        ld_d    = 1'b0;
        cnt_d   = '0;
        bit_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // mosi only moves on the falling edge of cpld_clk
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = ST_LATCH;
              ld_d    = 1'b1;
              mosi_d  = 1'b0;
            end else begin
              bit_d  = bit_q + 1'b1;
              word_d = word_q >> 1;
              mosi_d = word_q[1];
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          cnt_d   = '0;
          ld_d    = 1'b0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            fdone_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Control state, serial outputs, handshake flag and active buffer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      sclk_q    <= 1'b0;
      ld_q      <= 1'b0;
      mosi_q    <= 1'b0;
      fdone_q   <= 1'b0;
      pending_q <= 1'b0;
      act_ok_q  <= 1'b0;
      act_led_q <= '0;
      act_dig_q <= '0;
      act_dp_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      sclk_q    <= sclk_d;
      ld_q      <= ld_d;
      mosi_q    <= mosi_d;
      fdone_q   <= fdone_d;
      pending_q <= accept | (pending_q & ~xfer);
      if (xfer) begin
        act_ok_q  <= 1'b1;
        act_led_q <= shd_led_q;
        act_dig_q <= shd_dig_q;
        act_dp_q  <= shd_dp_q;
      end
    end
  end

  // Data registers: shift word and shadow buffer need no reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    if (accept) begin
      shd_led_q <= upd_led;
      shd_dig_q <= upd_digits;
      shd_dp_q  <= upd_dp;
    end
`ifdef CPLD_DISP_DIM_EN
    if (state_q == ST_LOAD && idx_q == '0) bright_q <= brightness;
`endif
  end

`ifdef CPLD_DISP_DIM_EN
  // Frame counter for dimming; segments shown only while fcnt <= brightness.
  always_ff @(posedge clk) begin
    if (!rstn) fcnt_q <= 3'd0;
    else if (fdone_d) fcnt_q <= fcnt_q + 3'd1;
  end
`endif

  // CPLD reset follows the system reset one cycle later.
  always_ff @(posedge clk) begin
    cpld_rstn_q <= rstn;
  end

  assign frame_done = fdone_q;
  assign cpld_clk   = sclk_q;
  assign cpld_ld    = ld_q;
  assign cpld_mosi  = mosi_q;
  assign cpld_rstn  = cpld_rstn_q;

endmodule

// File: tb/tb_cpld_disp_mux.sv
// Testbench for cpld_disp_mux (NUM_DIGITS=2, LED_W=8, CLK_DIV=2, HOLD_CYCLES=4).
// A monitor deserialises cpld_mosi on cpld_clk rising edges and queues each
// word at the latch pulse; the test compares queued words against tables.
module tb_cpld_disp_mux;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [7:0]  upd_led = '0;
  logic [7:0]  upd_digits = '0;
  logic [1:0]  upd_dp = '0;
  logic        blank = 1'b0;
`ifdef CPLD_DISP_DIM_EN
  logic [2:0]  brightness = 3'd7;
`endif
  logic        frame_done, cpld_clk, cpld_rstn, cpld_ld, cpld_mosi;

  int total = 0;
  int bad   = 0;

  cpld_disp_mux #(.NUM_DIGITS(2), .LED_W(8), .CLK_DIV(2), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_led(upd_led), .upd_digits(upd_digits), .upd_dp(upd_dp), .blank(blank),
`ifdef CPLD_DISP_DIM_EN
    .brightness(brightness),
`endif
    .frame_done(frame_done), .cpld_clk(cpld_clk), .cpld_rstn(cpld_rstn),
    .cpld_ld(cpld_ld), .cpld_mosi(cpld_mosi)
  );

  always #5 clk = ~clk;

  // Serial capture monitor
  logic [17:0] sh = '0;
  logic [17:0] wq[$];
  int nbits = 0, nbits_at_ld = 0, ld_len = 0, last_ld_len = 0;
  int cyc = 0, last_fd_cyc = 0, fd_period = 0;
  logic prev_sclk = 1'b0, prev_ld = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rstn) begin
      sh <= '0; nbits <= 0; ld_len <= 0; prev_sclk <= 1'b0; prev_ld <= 1'b0;
    end else begin
      prev_sclk <= cpld_clk;
      prev_ld   <= cpld_ld;
      if (cpld_clk && !prev_sclk) begin
        sh    <= {cpld_mosi, sh[17:1]};
        nbits <= nbits + 1;
      end
      if (cpld_ld) ld_len <= ld_len + 1;
      if (cpld_ld && !prev_ld) begin
        wq.push_back(sh);
        nbits_at_ld <= nbits;
        nbits <= 0;
      end
      if (!cpld_ld && prev_ld) begin
        last_ld_len <= ld_len;
        ld_len <= 0;
      end
      if (frame_done) begin
        if (last_fd_cyc > 0) fd_period <= cyc - last_fd_cyc;
        last_fd_cyc <= cyc;
      end
    end
  end

  typedef struct {
    logic [7:0]  led;
    logic [7:0]  dig;
    logic [1:0]  dp;
    logic        blank;
    logic [17:0] w0;
    logic [17:0] w1;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic get_word(output logic [17:0] w);
    int n = 0;
    while (wq.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (wq.size() == 0) begin
      chk("word_timeout", 32'd1, 32'd0);
      w = '0;
    end else begin
      w = wq.pop_front();
    end
  endtask

  // Returns on the negedge where frame_done is high, with the word queue emptied.
  task automatic wait_fd();
    int n = 0;
    while (frame_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (frame_done !== 1'b1) chk("frame_done_timeout", 32'd1, 32'd0);
    wq.delete();
  endtask

  task automatic send(input logic [7:0] led, input logic [7:0] dig, input logic [1:0] dp);
    int n = 0;
    upd_led = led; upd_digits = dig; upd_dp = dp; upd_valid = 1'b1;
    while (upd_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (upd_ready !== 1'b1) chk("ready_timeout", 32'd1, 32'd0);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  initial begin
    logic [17:0] w0, w1;
    int n, cnt0, cnt1;

    vecs[0] = '{8'hA5, 8'h31, 2'b00, 1'b0, {2'b01, 8'h06, 8'hA5}, {2'b10, 8'h4F, 8'hA5}};
    vecs[1] = '{8'h3C, 8'h88, 2'b10, 1'b0, {2'b01, 8'h7F, 8'h3C}, {2'b10, 8'hFF, 8'h3C}};
    vecs[2] = '{8'h3C, 8'h88, 2'b10, 1'b1, {2'b01, 8'h00, 8'h3C}, {2'b10, 8'h00, 8'h3C}};
    vecs[3] = '{8'hFF, 8'hF0, 2'b01, 1'b0, {2'b01, 8'hBF, 8'hFF}, {2'b10, 8'h71, 8'hFF}};
    vecs[4] = '{8'h00, 8'hDE, 2'b00, 1'b0, {2'b01, 8'h79, 8'h00}, {2'b10, 8'h5E, 8'h00}};
    vecs[5] = '{8'h81, 8'h2A, 2'b11, 1'b0, {2'b01, 8'hF7, 8'h81}, {2'b10, 8'hDB, 8'h81}};
    vecs[6] = '{8'h5A, 8'hB4, 2'b00, 1'b0, {2'b01, 8'h66, 8'h5A}, {2'b10, 8'h7C, 8'h5A}};
    vecs[7] = '{8'h01, 8'h9C, 2'b00, 1'b0, {2'b01, 8'h39, 8'h01}, {2'b10, 8'h6F, 8'h01}};
    vecs[8] = '{8'h80, 8'h75, 2'b00, 1'b0, {2'b01, 8'h6D, 8'h80}, {2'b10, 8'h07, 8'h80}};
    vecs[9] = '{8'h42, 8'h06, 2'b00, 1'b0, {2'b01, 8'h7D, 8'h42}, {2'b10, 8'h3F, 8'h42}};

    // Reset behaviour
    repeat (5) @(negedge clk);
    chk("rst_cpld_clk", {31'd0, cpld_clk}, 32'd0);
    chk("rst_cpld_ld", {31'd0, cpld_ld}, 32'd0);
    chk("rst_cpld_mosi", {31'd0, cpld_mosi}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_upd_ready", {31'd0, upd_ready}, 32'd1);
    chk("rst_cpld_rstn", {31'd0, cpld_rstn}, 32'd0);
    rstn = 1'b1;
    wq.delete();
    @(negedge clk);
    chk("cpld_rstn_release", {31'd0, cpld_rstn}, 32'd1);

    // First word after reset: digit 0, blank segments, cleared LEDs
    get_word(w0);
    chk("first_word", {14'd0, w0}, {14'd0, 18'b01_00000000_00000000});
    chk("first_word_bits", nbits_at_ld, 32'd18);
    n = 0;
    while (cpld_ld === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("ld_pulse_len", last_ld_len, 32'd4);

    // Table of update vectors, each shown in the frame after acceptance
    for (int i = 0; i < 10; i++) begin
      blank = vecs[i].blank;
      send(vecs[i].led, vecs[i].dig, vecs[i].dp);
      wait_fd();
      get_word(w0);
      get_word(w1);
      chk($sformatf("vec%0d_w0", i), {14'd0, w0}, {14'd0, vecs[i].w0});
      chk($sformatf("vec%0d_w1", i), {14'd0, w1}, {14'd0, vecs[i].w1});
    end
    blank = 1'b0;
    chk("frame_period", fd_period, 32'd162);

    // Back-to-back updates: second one waits for the frame-start transfer
    upd_led = vecs[0].led; upd_digits = vecs[0].dig; upd_dp = vecs[0].dp; upd_valid = 1'b1;
    n = 0;
    while (upd_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    upd_led = vecs[3].led; upd_digits = vecs[3].dig; upd_dp = vecs[3].dp;
    chk("b2b_ready_low", {31'd0, upd_ready}, 32'd0);
    n = 0;
    while (upd_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_ready_at_frame_start", {31'd0, frame_done}, 32'd1);
    wq.delete();
    @(negedge clk);
    upd_valid = 1'b0;
    chk("b2b_pending_kept", {31'd0, upd_ready}, 32'd0);
    get_word(w0);
    get_word(w1);
    chk("b2b_first_w0", {14'd0, w0}, {14'd0, vecs[0].w0});
    chk("b2b_first_w1", {14'd0, w1}, {14'd0, vecs[0].w1});
    get_word(w0);
    get_word(w1);
    chk("b2b_second_w0", {14'd0, w0}, {14'd0, vecs[3].w0});
    chk("b2b_second_w1", {14'd0, w1}, {14'd0, vecs[3].w1});

    // Reset in the middle of digit 1's shift
    wait_fd();
    get_word(w0);
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_cpld_clk", {31'd0, cpld_clk}, 32'd0);
    chk("midrst_cpld_ld", {31'd0, cpld_ld}, 32'd0);
    chk("midrst_cpld_mosi", {31'd0, cpld_mosi}, 32'd0);
    chk("midrst_cpld_rstn", {31'd0, cpld_rstn}, 32'd0);
    chk("midrst_upd_ready", {31'd0, upd_ready}, 32'd1);
    repeat (2) @(negedge clk);
    wq.delete();
    rstn = 1'b1;
    get_word(w0);
    get_word(w1);
    chk("midrst_w0", {14'd0, w0}, {14'd0, 18'b01_00000000_00000000});
    chk("midrst_w1", {14'd0, w1}, {14'd0, 18'b10_00000000_00000000});

`ifdef CPLD_DISP_DIM_EN
    // Dimming: brightness 0 shows segments 1 frame in 8, brightness 7 every frame
    brightness = 3'd0;
    send(vecs[0].led, vecs[0].dig, vecs[0].dp);
    wait_fd();
    cnt0 = 0; cnt1 = 0;
    for (int f = 0; f < 8; f++) begin
      get_word(w0);
      get_word(w1);
      if (w0[15:8] != 8'h00) cnt0++;
      if (w1[15:8] != 8'h00) cnt1++;
    end
    chk("dim0_digit0_frames", cnt0, 32'd1);
    chk("dim0_digit1_frames", cnt1, 32'd1);
    brightness = 3'd7;
    wait_fd();
    cnt0 = 0; cnt1 = 0;
    for (int f = 0; f < 8; f++) begin
      get_word(w0);
      get_word(w1);
      if (w0 == vecs[0].w0) cnt0++;
      if (w1 == vecs[0].w1) cnt1++;
    end
    chk("dim7_digit0_frames", cnt0, 32'd8);
    chk("dim7_digit1_frames", cnt1, 32'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
